// File: rtl/gnn_0_example_load.sv
`default_nettype none
// ============================================================================
// Module   : gnn_0_example_load
// Brief    : GNN load engine. Decodes a load instruction, launches the AXI
//            read master, then writes the returned stream beats into one of
//            four feature buffers at consecutive (wrapping) word addresses.
// Revision : 1.0 - initial release
// ============================================================================
module gnn_0_example_load #(
  parameter int LOAD_INST_LENGTH   = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BUF_ADDR_WIDTH   = 11
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          read_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] read_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  read_size,
  input  logic                          read_done,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_tdata,
  output logic                          load_write_buffer_1_A_wvalid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_1_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_A_data,
  output logic                          load_write_buffer_2_A_wvalid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_2_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_A_data,
  output logic                          load_write_buffer_1_B_wvalid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_1_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_B_data,
  output logic                          load_write_buffer_2_B_wvalid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_2_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_B_data
);

  localparam int c_len_w   = 16;
  localparam int c_fld_w   = 32;
  localparam int c_size_w  = 16;
  localparam int c_nports  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                        r_state;
  logic [c_len_w-1:0]            r_len;
  logic [c_len_w-1:0]            r_cnt;
  logic [C_BUF_ADDR_WIDTH-1:0]   r_start;
  logic [c_nports-1:0]           r_sel;
  logic                          r_rd_done;
  logic                          r_wvalid;
  logic [C_BUF_ADDR_WIDTH-1:0]   r_waddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;

  logic [C_M_AXI_ADDR_WIDTH-1:0] w_dram_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  w_size;
  logic [c_nports-1:0]           w_sel;
  logic                          w_accept;
  logic [c_len_w-1:0]            w_cnt_next;
  logic                          w_rd_done_next;
  logic                          w_finish;
  logic                          w_unused_bits;

  logic                          w_wv [c_nports];
  logic [C_BUF_ADDR_WIDTH-1:0]   w_wa [c_nports];
  logic [C_M_AXI_DATA_WIDTH-1:0] w_wd [c_nports];

  // Instruction field extraction; the DRAM address add drops its carry-out.
  assign w_dram_addr = {{(C_M_AXI_ADDR_WIDTH-c_fld_w){1'b0}}, ctrl_instruction[127:96]}
                       + ctrl_addr_offset;
  assign w_size      = {{(C_XFER_SIZE_WIDTH-c_size_w){1'b0}}, ctrl_instruction[95:80]};
  assign w_unused_bits = ^{ctrl_instruction[79:64], ctrl_instruction[47:43],
                           ctrl_instruction[31:6]};

  // Group field to one-hot buffer select; unknown encodings fall back to 1A.
  always_comb begin
    w_sel = 4'b0001;
    case (ctrl_instruction[5:0])
      6'b000001: w_sel = 4'b0001;
      6'b000010: w_sel = 4'b0010;
      6'b000100: w_sel = 4'b0100;
      6'b001000: w_sel = 4'b1000;
      default:   w_sel = 4'b0001;
    endcase
  end

  // Stream bookkeeping: next count includes this cycle's accept so the
  // registered ready drops right after the last beat.
  assign w_accept       = s_tvalid & s_tready;
  assign w_cnt_next     = r_cnt + {{(c_len_w-1){1'b0}}, w_accept};
  assign w_rd_done_next = r_rd_done | read_done;
  assign w_finish       = (w_cnt_next == r_len) && w_rd_done_next;

  // Control FSM with registered outputs and buffer write pipeline register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_start    <= '0;
      r_sel      <= '0;
      r_rd_done  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      ap_done    <= 1'b0;
      read_start <= 1'b0;
      read_addr  <= '0;
      read_size  <= '0;
      s_tready   <= 1'b0;
    end else begin
      ap_done    <= 1'b0;
      read_start <= 1'b0;
      r_wvalid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            read_addr <= w_dram_addr;
            read_size <= w_size;
            r_len     <= ctrl_instruction[63:48];
            r_start   <= ctrl_instruction[32 +: C_BUF_ADDR_WIDTH];
            r_sel     <= w_sel;
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rd_done <= w_rd_done_next;
          if (r_len == '0) begin
            r_state <= S_DONE;
          end else begin
            read_start <= 1'b1;
            s_tready   <= 1'b1;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          r_cnt     <= w_cnt_next;
          r_rd_done <= w_rd_done_next;
          s_tready  <= (w_cnt_next < r_len);
          if (w_accept) begin
            r_wvalid <= 1'b1;
            r_waddr  <= r_start + r_cnt[C_BUF_ADDR_WIDTH-1:0];
            r_wdata  <= s_tdata;
          end
          if (w_finish) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          ap_done <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fan the single write register out to the selected buffer port only.
  generate
    for (genvar p = 0; p < c_nports; p++) begin : g_port
      assign w_wv[p] = r_wvalid & r_sel[p];
      assign w_wa[p] = r_sel[p] ? r_waddr : '0;
      assign w_wd[p] = r_sel[p] ? r_wdata : '0;
    end
  endgenerate

  assign load_write_buffer_1_A_wvalid = w_wv[0];
  assign load_write_buffer_1_A_addr   = w_wa[0];
  assign load_write_buffer_1_A_data   = w_wd[0];
  assign load_write_buffer_2_A_wvalid = w_wv[1];
  assign load_write_buffer_2_A_addr   = w_wa[1];
  assign load_write_buffer_2_A_data   = w_wd[1];
  assign load_write_buffer_1_B_wvalid = w_wv[2];
  assign load_write_buffer_1_B_addr   = w_wa[2];
  assign load_write_buffer_1_B_data   = w_wd[2];
  assign load_write_buffer_2_B_wvalid = w_wv[3];
  assign load_write_buffer_2_B_addr   = w_wa[3];
  assign load_write_buffer_2_B_data   = w_wd[3];

endmodule
`default_nettype wire

// File: tb/tb_gnn_0_example_load.sv
`default_nettype none
// ============================================================================
// Module   : tb_gnn_0_example_load
// Brief    : Directed self-checking bench for the GNN load engine.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gnn_0_example_load;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_done;
  logic [63:0]  ctrl_addr_offset = '0;
  logic [127:0] ctrl_instruction = '0;
  logic         read_start;
  logic [63:0]  read_addr;
  logic [31:0]  read_size;
  logic         read_done = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [511:0] s_tdata = '0;
  logic         wv [4];
  logic [10:0]  wa [4];
  logic [511:0] wd [4];

  gnn_0_example_load dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .read_start(read_start), .read_addr(read_addr), .read_size(read_size),
    .read_done(read_done), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .load_write_buffer_1_A_wvalid(wv[0]), .load_write_buffer_1_A_addr(wa[0]),
    .load_write_buffer_1_A_data(wd[0]),
    .load_write_buffer_2_A_wvalid(wv[1]), .load_write_buffer_2_A_addr(wa[1]),
    .load_write_buffer_2_A_data(wd[1]),
    .load_write_buffer_1_B_wvalid(wv[2]), .load_write_buffer_1_B_addr(wa[2]),
    .load_write_buffer_1_B_data(wd[2]),
    .load_write_buffer_2_B_wvalid(wv[3]), .load_write_buffer_2_B_addr(wa[3]),
    .load_write_buffer_2_B_data(wd[3])
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int           port;
    int           addr;
    logic [511:0] data;
  } wr_t;

  wr_t         wq[$];
  int          cyc = 0;
  int          rs_cnt = 0;
  logic [63:0] rs_addr = '0;
  logic [31:0] rs_size = '0;
  int          rs_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          rd_cyc = 0;
  int          st_cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Posedge counter used as a timestamp for latency checks.
  always @(posedge aclk) cyc <= cyc + 1;

  // Record DUT output events away from the active edge.
  always @(negedge aclk) begin
    for (int p = 0; p < 4; p++) begin
      if (wv[p]) wq.push_back('{port: p, addr: int'(wa[p]), data: wd[p]});
    end
    if (read_start) begin
      rs_cnt  = rs_cnt + 1;
      rs_addr = read_addr;
      rs_size = read_size;
      rs_cyc  = cyc;
    end
    if (ap_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input int t, input int k);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = {16'hDA7A, 8'(t), 8'(i), 32'(k * 32'h01010101 + 32'h1000)};
    return d;
  endfunction

  function automatic logic [127:0] mkinst(input logic [31:0] addr, input logic [15:0] size,
                                          input logic [15:0] len, input logic [10:0] start,
                                          input logic [5:0] grp);
    return {addr, size, 16'h0, len, 5'h0, start, 26'h0, grp};
  endfunction

  task automatic chk_quiet(input string tag);
    logic [15:0] v;
    v = {ap_done, read_start, s_tready, |read_addr, |read_size,
         wv[0], wv[1], wv[2], wv[3], |wa[0], |wa[1], |wa[2], |wa[3],
         |{wd[0], wd[1]}, |wd[2], |wd[3]};
    chk(tag, v, 0);
  endtask

  task automatic start(input logic [127:0] inst);
    @(negedge aclk);
    ctrl_instruction = inst;
    ap_start = 1'b1;
    st_cyc = cyc;
    @(negedge aclk);
    ap_start = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge aclk);
    read_done = 1'b1;
    rd_cyc = cyc;
    @(negedge aclk);
    read_done = 1'b0;
  endtask

  // Offer n beats (optionally gapped); read_done pulses when beat rd_at is on the bus.
  task automatic send_beats(input int t, input int n, input int rd_at, input bit gaps);
    int idx = 0;
    int budget = 0;
    bit rd_sent = 0;
    while (idx < n && budget < 300) begin
      @(negedge aclk);
      budget++;
      read_done = 1'b0;
      if (!rd_sent && idx == rd_at) begin
        read_done = 1'b1;
        rd_sent = 1;
        rd_cyc = cyc;
      end
      s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = mkdata(t, idx);
      if (s_tvalid && s_tready) idx++;
    end
    @(negedge aclk);
    read_done = 1'b0;
    s_tvalid = 1'b0;
    chk("beat_budget", idx, n);
  endtask

  task automatic wait_done(input string tag, input int base);
    int budget = 0;
    while (done_cnt == base && budget < 100) begin
      @(negedge aclk);
      budget++;
    end
    repeat (3) @(negedge aclk);
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic chk_writes(input string tag, input int base, input int port,
                            input int st, input int n, input int t);
    chk({tag, "_nwr"}, wq.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < wq.size()) begin
        chk({tag, "_port"}, wq[base+k].port, port);
        chk({tag, "_addr"}, wq[base+k].addr, (st + k) % 2048);
        chk({tag, "_data"}, wq[base+k].data, mkdata(t, k));
      end
    end
  endtask

  initial begin
    int wb;
    int rb;
    int db;

    // Reset state
    repeat (3) @(negedge aclk);
    chk_quiet("reset_outputs");
    areset = 1'b0;
    @(negedge aclk);
    chk_quiet("post_reset_idle");

    // Basic transfer to 1A
    wb = wq.size(); rb = rs_cnt; db = done_cnt;
    ctrl_addr_offset = 64'h10000;
    start(mkinst(32'h1000, 16'd256, 16'd4, 11'h010, 6'b000001));
    send_beats(1, 4, 99, 1'b0);
    pulse_rd();
    wait_done("t1_done", db);
    chk("t1_rs_cnt", rs_cnt - rb, 1);
    chk("t1_rs_addr", rs_addr, 64'h11000);
    chk("t1_rs_size", rs_size, 256);
    chk("t1_rs_lat", rs_cyc - st_cyc, 2);
    chk("t1_done_lat", done_cyc - rd_cyc, 2);
    chk_writes("t1", wb, 0, 16, 4, 1);

    // Gapped stream to 2B, read_done before last beat, extra beat refused
    wb = wq.size(); rb = rs_cnt; db = done_cnt;
    ctrl_addr_offset = 64'h0;
    start(mkinst(32'h2000_0000, 16'd512, 16'd8, 11'd100, 6'b001000));
    send_beats(2, 8, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_tvalid = 1'b1;
      s_tdata  = mkdata(2, 8);
      chk("t2_no_ready", s_tready, 0);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    wait_done("t2_done", db);
    chk("t2_rs_addr", rs_addr, 64'h2000_0000);
    chk_writes("t2", wb, 3, 100, 8, 2);

    // Address wrap, default group, read_done with the last beat
    wb = wq.size(); db = done_cnt;
    start(mkinst(32'h40, 16'd128, 16'd4, 11'd2046, 6'b110000));
    send_beats(3, 4, 3, 1'b0);
    wait_done("t3_done", db);
    chk_writes("t3", wb, 0, 2046, 4, 3);

    // Zero length
    wb = wq.size(); rb = rs_cnt; db = done_cnt;
    start(mkinst(32'h80, 16'd64, 16'd0, 11'd7, 6'b000100));
    wait_done("t4_done", db);
    chk("t4_no_rs", rs_cnt - rb, 0);
    chk("t4_no_wr", wq.size() - wb, 0);
    chk("t4_lat_ok", ((done_cyc - st_cyc) <= 3) && ((done_cyc - st_cyc) >= 1), 1);

    // Ignored re-start during STREAM, then reset mid-transfer
    wb = wq.size(); rb = rs_cnt; db = done_cnt;
    start(mkinst(32'h100, 16'd384, 16'd6, 11'd20, 6'b000010));
    send_beats(5, 2, 99, 1'b0);
    start(mkinst(32'h900, 16'd64, 16'd1, 11'd0, 6'b000001));
    repeat (4) @(negedge aclk);
    chk("t5_rs_once", rs_cnt - rb, 1);
    chk_writes("t5a", wb, 1, 20, 2, 5);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk_quiet("t5_reset_clear");
    @(negedge aclk);
    areset = 1'b0;
    chk("t5_no_done", done_cnt - db, 0);
    wb = wq.size(); db = done_cnt;
    start(mkinst(32'h300, 16'd128, 16'd2, 11'd5, 6'b000100));
    send_beats(6, 2, 99, 1'b0);
    pulse_rd();
    wait_done("t5_done", db);
    chk_writes("t5b", wb, 2, 5, 2, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
